// File: rtl/mem_arbiter.sv
// Single-ported memory arbiter between instruction fetch (read-only) and data
// access (read/write); data has priority, a starvation counter forces fetch.
module mem_arbiter #(
    parameter int ADDR_W     = 16,
    parameter int DATA_W     = 16,
    parameter int STARVE_MAX = 2,
    parameter int TIMEOUT    = 255
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_req,
    input  logic [ADDR_W-1:0] i_addr,
    output logic [DATA_W-1:0] i_rdata,
    output logic              i_done,
    input  logic              d_req,
    input  logic              d_wr,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic [DATA_W-1:0] d_rdata,
    output logic              d_done,
    output logic              mem_en,
    output logic              mem_wr,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_valid,
    output logic [1:0]        grant,
    output logic              busy,
    output logic              err
);
    localparam int SC_W = (STARVE_MAX < 1) ? 1 : $clog2(STARVE_MAX + 1);
    localparam int TO_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);

    localparam logic [1:0] GNT_NONE  = 2'b00;
    localparam logic [1:0] GNT_FETCH = 2'b01;
    localparam logic [1:0] GNT_DATA  = 2'b10;

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;

    state_t          state;
    logic [SC_W-1:0] starve_cnt;
    logic [TO_W-1:0] to_cnt;
    logic            fetch_forced;
    logic            pick_data;
    logic            pick_fetch;
    logic            to_hit;

    // Fetch is forced only when it is waiting and data already won STARVE_MAX times in a row.
    always_comb begin
        fetch_forced = i_req && (starve_cnt == SC_W'(STARVE_MAX));
        pick_data    = d_req && !fetch_forced;
        pick_fetch   = !pick_data && i_req;
        to_hit       = (int'(to_cnt) >= TIMEOUT - 1);
    end

    assign busy = (state != IDLE);

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            grant      <= GNT_NONE;
            mem_en     <= 1'b0;
            mem_wr     <= 1'b0;
            mem_addr   <= '0;
            mem_wdata  <= '0;
            i_rdata    <= '0;
            d_rdata    <= '0;
            i_done     <= 1'b0;
            d_done     <= 1'b0;
            err        <= 1'b0;
            starve_cnt <= '0;
            to_cnt     <= '0;
        end else begin
            mem_en <= 1'b0;
            i_done <= 1'b0;
            d_done <= 1'b0;
            err    <= 1'b0;
            case (state)
                IDLE: begin
                    if (pick_data) begin
                        grant     <= GNT_DATA;
                        mem_addr  <= d_addr;
                        mem_wr    <= d_wr;
                        mem_wdata <= d_wdata;
                        mem_en    <= 1'b1;
                        state     <= ISSUE;
                        if (i_req && !fetch_forced)
                            starve_cnt <= starve_cnt + 1'b1;
                    end else if (pick_fetch) begin
                        grant      <= GNT_FETCH;
                        mem_addr   <= i_addr;
                        mem_wr     <= 1'b0;
                        mem_en     <= 1'b1;
                        starve_cnt <= '0;
                        state      <= ISSUE;
                    end
                end
                ISSUE: begin
                    to_cnt <= '0;
                    state  <= WAIT;
                end
                WAIT: begin
                    if (mem_valid) begin
                        if (grant == GNT_FETCH) begin
                            i_rdata <= mem_rdata;
                            i_done  <= 1'b1;
                        end else begin
                            if (!mem_wr)
                                d_rdata <= mem_rdata;
                            d_done <= 1'b1;
                        end
                        state <= DONE;
                    end else if (to_hit) begin
                        // Abort: the owner sees all-ones data together with err.
                        if (grant == GNT_FETCH) begin
                            i_rdata <= '1;
                            i_done  <= 1'b1;
                        end else begin
                            d_rdata <= '1;
                            d_done  <= 1'b1;
                        end
                        err   <= 1'b1;
                        state <= DONE;
                    end else begin
                        to_cnt <= to_cnt + 1'b1;
                    end
                end
                DONE: begin
                    grant  <= GNT_NONE;
                    mem_wr <= 1'b0;
                    state  <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_mem_arbiter.sv
// Randomized bench for mem_arbiter: agents for fetch, data and memory, and a
// transaction-level reference model that predicts every grant and completion.
module tb_mem_arbiter;
    localparam int AW = 16, DW = 16, SMAX = 2, TMO = 255;

    logic          clk = 1'b0, rst = 1'b1;
    logic          i_req = 1'b0, d_req = 1'b0, d_wr = 1'b0, mem_valid = 1'b0;
    logic [AW-1:0] i_addr = '0, d_addr = '0;
    logic [DW-1:0] d_wdata = '0, mem_rdata = '0;
    logic [DW-1:0] i_rdata, d_rdata, mem_wdata;
    logic [AW-1:0] mem_addr;
    logic          i_done, d_done, mem_en, mem_wr, busy, err;
    logic [1:0]    grant;

    always #5 clk = ~clk;

    mem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .STARVE_MAX(SMAX), .TIMEOUT(TMO)) dut (
        .clk(clk), .rst(rst),
        .i_req(i_req), .i_addr(i_addr), .i_rdata(i_rdata), .i_done(i_done),
        .d_req(d_req), .d_wr(d_wr), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_rdata(d_rdata), .d_done(d_done),
        .mem_en(mem_en), .mem_wr(mem_wr), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .mem_valid(mem_valid),
        .grant(grant), .busy(busy), .err(err)
    );

    int n_vec = 0, n_err = 0;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h want %h at %0t", tag, act, exp, $time);
        end
    endtask

    bit          agents_on = 0, mon_on = 0, mem_mute = 0;
    int          gap = 3, renew = 50, cyc = 0;
    bit          en_q = 0, i_done_q = 0, d_done_q = 0;
    logic [DW-1:0] mem [256];
    logic [DW-1:0] ref_mem [256];

    typedef struct {
        bit            own_d;
        bit            wr;
        logic [AW-1:0] addr;
        logic [DW-1:0] wdata;
    } acc_t;

    // Reference model: per-access expectations from the arbitration rules.
    initial begin
        acc_t          cur;
        int            ph, en_cyc, bypass;
        bit            exp_err;
        logic [DW-1:0] exp_rd, i_rd_exp, d_rd_exp;
        ph = 0; en_cyc = 0; bypass = 0; exp_err = 0;
        exp_rd = '0; i_rd_exp = '0; d_rd_exp = '0;
        cur = '{1'b0, 1'b0, '0, '0};
        forever begin
            @(negedge clk);
            cyc++;
            en_q = mem_en; i_done_q = i_done; d_done_q = d_done;
            if (!mon_on) begin
                ph = 0; bypass = 0;
                continue;
            end
            chk("busy", busy, ph != 0);
            chk("grant", grant, (ph == 0) ? 2'b00 : (cur.own_d ? 2'b10 : 2'b01));
            if (ph != 3) chk("no_done", {i_done, d_done, err}, 3'b000);
            if (ph != 1) chk("no_en", mem_en, 0);
            case (ph)
                0: begin
                    if (d_req && !(i_req && bypass == SMAX)) begin
                        cur = '{1'b1, d_wr, d_addr, d_wdata};
                        if (i_req) bypass++;
                        ph = 1;
                    end else if (i_req) begin
                        cur = '{1'b0, 1'b0, i_addr, '0};
                        bypass = 0;
                        ph = 1;
                    end
                end
                1: begin
                    chk("mem_en", mem_en, 1);
                    chk("mem_addr", mem_addr, cur.addr);
                    chk("mem_wr", mem_wr, cur.wr);
                    if (cur.wr) begin
                        chk("mem_wdata", mem_wdata, cur.wdata);
                        ref_mem[cur.addr[7:0]] = cur.wdata;
                    end
                    en_cyc = cyc;
                    ph = 2;
                end
                2: begin
                    if (mem_valid) begin
                        exp_err = 0; exp_rd = ref_mem[cur.addr[7:0]]; ph = 3;
                    end else if (cyc - en_cyc == TMO) begin
                        exp_err = 1; exp_rd = 16'hFFFF; ph = 3;
                    end
                end
                default: begin
                    chk("i_done", i_done, !cur.own_d);
                    chk("d_done", d_done, cur.own_d);
                    chk("err", err, exp_err);
                    if (cur.own_d) begin
                        if (!cur.wr) d_rd_exp = exp_rd;
                        chk("d_rdata", d_rdata, d_rd_exp);
                    end else begin
                        i_rd_exp = exp_rd;
                        chk("i_rdata", i_rdata, i_rd_exp);
                    end
                    ph = 0;
                end
            endcase
        end
    end

    // Fetch agent
    initial forever begin
        @(posedge clk); #1;
        if (i_req) begin
            if (i_done_q) begin
                if (agents_on && $urandom_range(99, 0) < renew) i_addr = 16'($urandom);
                else i_req = 0;
            end
        end else if (agents_on && $urandom_range(gap, 0) == 0) begin
            i_req = 1; i_addr = 16'($urandom);
        end
    end

    // Data agent
    initial forever begin
        @(posedge clk); #1;
        if (d_req) begin
            if (d_done_q) begin
                if (agents_on && $urandom_range(99, 0) < renew) begin
                    d_wr = 1'($urandom); d_addr = 16'($urandom); d_wdata = 16'($urandom);
                end else d_req = 0;
            end
        end else if (agents_on && $urandom_range(gap, 0) == 0) begin
            d_req = 1; d_wr = 1'($urandom); d_addr = 16'($urandom); d_wdata = 16'($urandom);
        end
    end

    // Memory agent: latency 1..3, occasional hang on reads, stray valids when idle
    initial begin
        bit pend, hang;
        int cnt, reads;
        pend = 0; hang = 0; cnt = 0; reads = 0;
        forever begin
            @(posedge clk); #1;
            if (mem_mute) begin
                pend = 0; hang = 0;
                continue;
            end
            mem_valid = 0;
            if (hang && (i_done_q || d_done_q)) hang = 0;
            if (en_q && !rst) begin
                if (mem_wr) mem[mem_addr[7:0]] = mem_wdata;
                else reads++;
                hang = !mem_wr && (reads == 5 || $urandom_range(80, 0) == 0);
                pend = !hang;
                cnt = $urandom_range(3, 1);
            end
            if (pend) begin
                cnt--;
                if (cnt == 0) begin
                    mem_valid = 1; mem_rdata = mem[mem_addr[7:0]]; pend = 0;
                end
            end else if (!hang && $urandom_range(9, 0) == 0) begin
                mem_valid = 1; mem_rdata = 16'($urandom);
            end
        end
    end

    initial begin
        #600000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int t;
        for (int i = 0; i < 256; i++) begin
            mem[i]     = 16'(i * 257) ^ 16'hA5A5;
            ref_mem[i] = 16'(i * 257) ^ 16'hA5A5;
        end
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_busy", busy, 0);
        chk("rst_grant", grant, 0);
        chk("rst_ctl", {mem_en, mem_wr, i_done, d_done, err}, 0);
        chk("rst_addr", mem_addr, 0);
        chk("rst_wdata", mem_wdata, 0);
        chk("rst_rdata", {i_rdata, d_rdata}, 0);

        @(posedge clk); #1;
        rst = 0; mon_on = 1; agents_on = 1; gap = 4; renew = 40;
        repeat (2500) @(posedge clk);
        #1 gap = 0; renew = 100;
        repeat (600) @(posedge clk);
        #1 agents_on = 0;

        t = 0;
        while ((i_req || d_req || busy) && t < 2000) begin
            @(negedge clk); t++;
        end
        chk("drain_timeout", t < 2000, 1);
        @(posedge clk); #1;
        mon_on = 0; mem_mute = 1; mem_valid = 0; i_req = 0; d_req = 0;

        // Reset while an access is stuck in WAIT, then a late mem_valid.
        @(posedge clk); #1;
        d_req = 1; d_wr = 0; d_addr = 16'h0005;
        repeat (3) @(posedge clk);
        #1 rst = 1; d_req = 0;
        @(negedge clk);
        chk("wait_busy", busy, 1);
        chk("wait_grant", grant, 2'b10);
        @(posedge clk); #1 rst = 0;
        @(negedge clk);
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_grant", grant, 0);
        chk("mid_rst_ctl", {mem_en, i_done, d_done, err}, 0);
        chk("mid_rst_data", {mem_addr, d_rdata}, 0);
        @(posedge clk); #1 mem_valid = 1; mem_rdata = 16'hBEEF;
        @(posedge clk); #1 mem_valid = 0;
        repeat (4) begin
            @(negedge clk);
            chk("late_valid_ctl", {busy, i_done, d_done, err, mem_en}, 0);
            chk("late_valid_rdata", d_rdata, 0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Shares one single-ported backing memory between the instruction-fetch path (read-only) and the data-memory path (read/write) of the pipelined CPU.
- Sequences each access as grant → issue → wait for memory valid → done.
- Feeds done/busy back to the fetch and memory stages, which use them to stall.
- Data side has priority; a starvation counter guarantees fetch progress.

Parameters:
ADDR_W, 16, address width
DATA_W, 16, data width
STARVE_MAX, 2, consecutive data grants allowed while i_req is pending before fetch is forced
TIMEOUT, 255, WAIT-state cycles before the access is aborted with error

Ports:
clk  in  1  clock, all state on rising edge
rst  in  1  synchronous reset, active-high
i_req  in  1  fetch request; held high, i_addr stable, until i_done
i_addr  in  ADDR_W  fetch address
i_rdata  out  DATA_W  fetch read data, valid when i_done=1
i_done  out  1  one-cycle completion pulse to fetch
d_req  in  1  data request; held high, fields stable, until d_done
d_wr  in  1  1=write, 0=read
d_addr  in  ADDR_W  data address
d_wdata  in  DATA_W  write data
d_rdata  out  DATA_W  data read result, valid when d_done=1
d_done  out  1  one-cycle completion pulse to data path
mem_en  out  1  memory command strobe, exactly one cycle per access
mem_wr  out  1  memory write qualifier (valid with mem_en)
mem_addr  out  ADDR_W  memory address (held from ISSUE until IDLE)
mem_wdata  out  DATA_W  memory write data
mem_rdata  in  DATA_W  memory read data, valid with mem_valid
mem_valid  in  1  memory completion (read data or write ack)
grant  out  2  current owner: 2'b00 none, 2'b01 fetch, 2'b10 data
busy  out  1  1 in any state except IDLE
err  out  1  one-cycle pulse with done on timeout abort

Behaviour:
- Interface: one clock `clk`; reset `rst` is synchronous and active-high.
- Reset (sync, active-high, any state, including mid-access):
  - Next edge: state=IDLE; grant, busy, mem_en, mem_wr, i_done, d_done, err = 0.
  - mem_addr, mem_wdata, i_rdata, d_rdata = 0; starve_cnt = 0; timeout counter = 0.
  - An aborted access produces no done.
- FSM states: IDLE, ISSUE, WAIT, DONE.
- IDLE:
  - Grant selection:
    - d_req and not (i_req and starve_cnt==STARVE_MAX): grant data.
    - Else if i_req: grant fetch.
    - Else stay in IDLE.
  - On grant, latch addr/wr/wdata (wr=0 for fetch) into the mem_* registers and set grant.
  - Next state ISSUE.
- ISSUE: mem_en=1 for this cycle only; clear timeout counter; next state WAIT.
- WAIT:
  - On mem_valid: capture mem_rdata into the owner's rdata register (data writes leave d_rdata unchanged); next state DONE.
  - Else increment the timeout counter; at TIMEOUT, load rdata with all-ones, set the err flag, and go to DONE.
- DONE:
  - Owner's done=1 for one cycle; err=1 if the access timed out; next state IDLE; grant cleared on exit.
  - Requests are not sampled in DONE; the requester drops req on the same edge.
- mem_valid outside WAIT is ignored.
- starve_cnt:
  - +1 (saturating at STARVE_MAX) on each data grant made while i_req=1.
  - Cleared on any fetch grant.
  - Unchanged on a data grant while i_req=0.
- Latency: req high in IDLE at cycle 0 → mem_en cycle 1 → earliest mem_valid cycle 2 → done cycle 3.
  - Back-to-back accesses: 4 cycles minimum each.
- Simultaneous i_req and d_req in IDLE with starve_cnt<STARVE_MAX: data wins.
- Request deasserted illegally mid-access: the access still completes and done still pulses.

Test Plan:
- Reset then i_req=1, i_addr=16'h0010; memory returns 16'hA5A5 one cycle after mem_en → mem_en at cycle 1 with mem_addr=0010, mem_wr=0; i_done=1 and i_rdata=A5A5 at cycle 3; grant=01 over cycles 1–3.
- d_req, d_wr=1, d_addr=16'h0040, d_wdata=16'h1234 → mem_wr=1 with mem_wdata=1234 on mem_en; d_done pulses; d_rdata keeps its prior value.
- i_req and d_req held continuously, STARVE_MAX=2 → grant sequence data, data, fetch, data, data, fetch.
- mem_valid held 0 after mem_en, TIMEOUT=255 → d_done and err pulse together 256 cycles after ISSUE; d_rdata=FFFF; returns to IDLE.
- rst asserted during WAIT → next edge busy=0, grant=00, no done pulse; a mem_valid arriving afterward is ignored.
- mem_valid pulsed while IDLE with no request → no done, no state change.
